// File: rtl/segment_sequencer.sv
// Segment sequencer: walks 128-bit segment words out of a FIFO, runs or waits for a retrigger,
// and keeps a one-deep prefetch so back-to-back run segments switch without a gap.
module segment_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic             refclk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [127:0]     fifo_dout,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   output logic             fifo_rst,
   input  logic             retrigger,
   input  logic             seg_done,
   output logic             seg_load,
   output logic             gen_enable,
   output logic [47:0]      seg_on,
   output logic [47:0]      seg_off,
   output logic [31:0]      seg_repeat,
   output logic             busy,
   output logic [1:0]       status,
   output logic [CNT_W-1:0] seg_count,
   output logic [CNT_W-1:0] timeout_count,
   output logic [31:0]      wait_samples
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_WAIT  = 2'd3;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   function automatic logic is_run_seg(input logic [127:0] word);
      return word[31:0] != 32'd0;
   endfunction

   logic [1:0]       state_q, state_d;
   logic [127:0]     cur_q, cur_d;
   logic [127:0]     nxt_q, nxt_d;
   logic             nxt_valid_q, nxt_valid_d;
   logic             rd_pend_q, rd_pend_d;
   logic [1:0]       status_q, status_d;
   logic [CNT_W-1:0] seg_count_q, seg_count_d;
   logic [CNT_W-1:0] timeout_count_q, timeout_count_d;
   logic [31:0]      wait_samples_q, wait_samples_d;
   logic [47:0]      wait_cnt_q, wait_cnt_d;
   logic             seg_load_q, seg_load_d;
   logic             fifo_rst_q, fifo_rst_d;
   logic             gen_enable_q;
   logic             busy_q;
   logic             rtrig_prev_q;
   logic             rd_en_s;
   logic             match_s;
   logic             timeout_s;
   logic             advance_s;

   // Next-state decode: FSM, prefetch shadow, run counters; abort overrides everything at the end.
   always_comb begin
      state_d         = state_q;
      cur_d           = cur_q;
      nxt_d           = nxt_q;
      nxt_valid_d     = nxt_valid_q;
      rd_pend_d       = rd_pend_q;
      status_d        = status_q;
      seg_count_d     = seg_count_q;
      timeout_count_d = timeout_count_q;
      wait_samples_d  = wait_samples_q;
      wait_cnt_d      = wait_cnt_q;
      seg_load_d      = 1'b0;
      fifo_rst_d      = 1'b0;
      rd_en_s         = 1'b0;

      // off[0] selects edge mode, off[1] the level to wait for, on is the timeout
      match_s   = (retrigger == cur_q[33]) && (!cur_q[32] || (retrigger != rtrig_prev_q));
      timeout_s = (cur_q[127:80] != 48'd0) && (wait_cnt_q == cur_q[127:80]);
      advance_s = ((state_q == S_RUN) && seg_done) ||
                  ((state_q == S_WAIT) && (match_s || timeout_s));

      case (state_q)
         S_IDLE: begin
            if (start && !fifo_empty) begin
               rd_en_s         = 1'b1;
               rd_pend_d       = 1'b1;
               status_d        = 2'b00;
               seg_count_d     = {CNT_W{1'b0}};
               timeout_count_d = {CNT_W{1'b0}};
               wait_samples_d  = 32'd0;
               state_d         = S_FETCH;
            end else if (start) begin
               status_d = 2'b01;
            end else begin
               status_d = status_q;
            end
         end
         S_FETCH: begin
            cur_d     = fifo_dout;
            rd_pend_d = 1'b0;
            if (is_run_seg(fifo_dout)) begin
               seg_load_d = 1'b1;
               state_d    = S_RUN;
            end else begin
               wait_cnt_d = 48'd0;
               state_d    = S_WAIT;
            end
         end
         S_RUN, S_WAIT: begin
            if (state_q == S_WAIT) begin
               wait_cnt_d     = wait_cnt_q + 48'd1;
               wait_samples_d = wait_samples_q + 32'd1;
            end else begin
               wait_cnt_d = wait_cnt_q;
            end
            if (!nxt_valid_q && !rd_pend_q && !fifo_empty && !abort) begin
               rd_en_s   = 1'b1;
               rd_pend_d = 1'b1;
            end else begin
               rd_en_s = 1'b0;
            end
            if (advance_s) begin
               seg_count_d = seg_count_q + CNT_ONE;
               if ((state_q == S_WAIT) && timeout_s && !match_s && (timeout_count_q != CNT_MAX)) begin
                  timeout_count_d = timeout_count_q + CNT_ONE;
               end else begin
                  timeout_count_d = timeout_count_q;
               end
               if (nxt_valid_q) begin
                  cur_d       = nxt_q;
                  nxt_valid_d = 1'b0;
                  if (is_run_seg(nxt_q)) begin
                     seg_load_d = 1'b1;
                     state_d    = S_RUN;
                  end else begin
                     wait_cnt_d = 48'd0;
                     state_d    = S_WAIT;
                  end
               end else if (rd_pend_q || !fifo_empty) begin
                  // the outstanding (or just-issued) read lands in cur via FETCH
                  rd_pend_d = 1'b1;
                  state_d   = S_FETCH;
               end else begin
                  status_d   = 2'b01;
                  fifo_rst_d = 1'b1;
                  state_d    = S_IDLE;
               end
            end else if (rd_pend_q) begin
               nxt_d       = fifo_dout;
               nxt_valid_d = 1'b1;
               rd_pend_d   = 1'b0;
            end else begin
               nxt_valid_d = nxt_valid_q;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (abort && (state_q != S_IDLE)) begin
         state_d         = S_IDLE;
         status_d        = 2'b10;
         fifo_rst_d      = 1'b1;
         nxt_valid_d     = 1'b0;
         rd_pend_d       = 1'b0;
         seg_load_d      = 1'b0;
         cur_d           = cur_q;
         nxt_d           = nxt_q;
         seg_count_d     = seg_count_q;
         timeout_count_d = timeout_count_q;
         wait_samples_d  = wait_samples_q;
         wait_cnt_d      = wait_cnt_q;
      end else begin
         fifo_rst_d = fifo_rst_d;
      end
   end

   // State and output registers.
   always_ff @(posedge refclk or posedge reset) begin
      if (reset) begin
         state_q         <= S_IDLE;
         cur_q           <= 128'd0;
         nxt_q           <= 128'd0;
         nxt_valid_q     <= 1'b0;
         rd_pend_q       <= 1'b0;
         status_q        <= 2'b00;
         seg_count_q     <= {CNT_W{1'b0}};
         timeout_count_q <= {CNT_W{1'b0}};
         wait_samples_q  <= 32'd0;
         wait_cnt_q      <= 48'd0;
         seg_load_q      <= 1'b0;
         fifo_rst_q      <= 1'b0;
         gen_enable_q    <= 1'b0;
         busy_q          <= 1'b0;
         rtrig_prev_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         cur_q           <= cur_d;
         nxt_q           <= nxt_d;
         nxt_valid_q     <= nxt_valid_d;
         rd_pend_q       <= rd_pend_d;
         status_q        <= status_d;
         seg_count_q     <= seg_count_d;
         timeout_count_q <= timeout_count_d;
         wait_samples_q  <= wait_samples_d;
         wait_cnt_q      <= wait_cnt_d;
         seg_load_q      <= seg_load_d;
         fifo_rst_q      <= fifo_rst_d;
         gen_enable_q    <= (state_d == S_RUN);
         busy_q          <= (state_d != S_IDLE);
         rtrig_prev_q    <= retrigger;
      end
   end

   // The read strobe must land in the cycle before the data is consumed, so it is decoded, not registered.
   assign fifo_rd_en    = rd_en_s && !reset;
   assign fifo_rst      = fifo_rst_q;
   assign seg_load      = seg_load_q;
   assign gen_enable    = gen_enable_q;
   assign seg_on        = cur_q[127:80];
   assign seg_off       = cur_q[79:32];
   assign seg_repeat    = cur_q[31:0];
   assign busy          = busy_q;
   assign status        = status_q;
   assign seg_count     = seg_count_q;
   assign timeout_count = timeout_count_q;
   assign wait_samples  = wait_samples_q;

endmodule

// File: doc/segment_sequencer.md
SEGMENT_SEQUENCER -- requirements
Module: segment_sequencer

Interface
REQ-001 The module SHALL be clocked by a single clock; the reset is asynchronous and active-high.
REQ-002 Parameter: CNT_W, default 16, width of seg_count and timeout_count.
REQ-003 Ports SHALL be:
refclk  in  1  sole clock
reset  in  1  async active-high reset
start  in  1  one-cycle generate trigger
abort  in  1  one-cycle abort trigger
fifo_dout  in  128  segment word; valid the cycle after fifo_rd_en
fifo_empty  in  1  segment FIFO empty
fifo_rd_en  out  1  one-cycle FIFO read pulse
fifo_rst  out  1  one-cycle FIFO reset pulse
retrigger  in  1  debounced retrigger level, synchronous to refclk
seg_done  in  1  pulse from clock core: current segment finished all repeats
seg_load  out  1  one-cycle pulse: new segment on seg_on/seg_off/seg_repeat
gen_enable  out  1  clock core may run
seg_on  out  48  current on_counts
seg_off  out  48  current off_counts
seg_repeat  out  32  current repeat_counts
busy  out  1  state != IDLE
status  out  2  [0] finished normally, [1] aborted
seg_count  out  CNT_W  segments advanced this run
timeout_count  out  CNT_W  retrigger waits ended by timeout
wait_samples  out  32  cycles spent in WAIT_RTRIG this run

Function
REQ-004 Segment word decode SHALL be on=[127:80], off=[79:32], repeat=[31:0]; repeat==0 marks a retrigger segment: off[0]=edge mode, off[1]=required level, on=timeout in cycles (0 = none).
REQ-005 Registers SHALL be: cur (segment driving outputs), nxt plus nxt_valid (prefetch shadow), rd_pend (read issued, data due next cycle).
REQ-006 States SHALL be IDLE, FETCH, RUN, WAIT_RTRIG.
REQ-007 IDLE: gen_enable=0; on start with fifo_empty=0, pulse fifo_rd_en, clear status/seg_count/timeout_count/wait_samples, go FETCH.
REQ-008 IDLE, start with fifo_empty=1: status=2'b01, stay IDLE, no read.
REQ-009 FETCH: capture fifo_dout into cur; next state RUN if repeat!=0 (pulse seg_load that same capture cycle), else WAIT_RTRIG with wait counter cleared.
REQ-010 RUN: gen_enable=1; WAIT_RTRIG: gen_enable=0, wait counter and wait_samples increment by 1 each cycle.
REQ-011 Prefetch: in RUN or WAIT_RTRIG, if nxt_valid=0, rd_pend=0, fifo_empty=0, pulse fifo_rd_en; next cycle load nxt, set nxt_valid.
REQ-012 Advance event = seg_done in RUN, or retrigger exit in WAIT_RTRIG; seg_count increments by 1 (wraps).
REQ-013 Advance with nxt_valid=1: cur<=nxt, nxt_valid<=0, zero-gap; enter RUN with seg_load pulse if nxt.repeat!=0, else WAIT_RTRIG.
REQ-014 Advance with nxt_valid=0 and rd_pend=1: go FETCH (gen_enable=0 one cycle); data captured into cur, not nxt.
REQ-015 Advance with nxt_valid=0, rd_pend=0, fifo_empty=1: go IDLE, status[0]=1, pulse fifo_rst.
REQ-016 Retrigger exit when: (off[0]=0 and retrigger==off[1]) or (off[0]=1 and retrigger==off[1] and retrigger differs from previous-cycle value) or (on!=0 and wait counter==on).
REQ-017 Match and timeout in same cycle SHALL count as match; timeout_count increments only on pure timeout, saturating at all-ones.
REQ-018 Abort in any non-IDLE state SHALL take priority over all events: go IDLE, status[1]=1, pulse fifo_rst, clear nxt_valid/rd_pend, gen_enable=0 same edge. Abort in IDLE ignored.
REQ-019 start while busy SHALL be ignored; seg_done outside RUN ignored.
REQ-020 status and counters SHALL hold after run end until next accepted start.

Reset
REQ-021 reset SHALL force IDLE, all outputs and registers 0 (seg_on/seg_off/seg_repeat=0, fifo_rd_en=fifo_rst=0) immediately; reset mid-run SHALL not pulse fifo_rst.

Verification
REQ-022 Two segments (repeat=3, repeat=5) preloaded, start, seg_done pulses -> seg_load on each, zero gap at switch, seg_count=2, status=01, fifo_rst one pulse.
REQ-023 Retrigger segment level mode, off[1]=1, on=0, retrigger raised after 40 cycles -> wait_samples=40 or 41 per REQ-010, timeout_count=0, next segment loads.
REQ-024 Retrigger edge mode, retrigger held high from entry, on=100 -> no edge, exit at timeout, timeout_count=1.
REQ-025 Abort asserted same cycle as seg_done -> IDLE, status=10, seg_count not incremented.
REQ-026 start with empty FIFO -> status=01, no fifo_rd_en; start while busy -> no effect.
REQ-027 FIFO refilled only after seg_done with rd_pend -> FETCH stall, gen_enable low exactly 1 cycle.
